// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM state encoding, forward-select
// codes and the per-operand forwarding decision.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // EX/MEM is the younger producer, so it wins a double match; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd,
                                         input logic       mem_we,
                                         input logic [4:0] wb_rd,
                                         input logic       wb_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle: register fields in, stall/flush/forward controls out.
// Handshake: none; every control is level-sensitive and valid each cycle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic [4:0]       id_ex_rs1;
    logic [4:0]       id_ex_rs2;
    logic             id_ex_memread;
    logic [4:0]       ex_mem_rd;
    logic [4:0]       mem_wb_rd;
    logic             ex_mem_regwrite;
    logic             mem_wb_regwrite;
    logic             branch_taken;
    logic             ex_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             id_ex_hold;
    logic             ex_mem_flush;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mc_timeout_err;

    modport master (
        output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_memread,
               ex_mem_rd, mem_wb_rd, ex_mem_regwrite, mem_wb_regwrite,
               branch_taken, ex_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold,
               ex_mem_flush, forward_a, forward_b, stall_cnt, flush_cnt,
               mc_timeout_err
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_memread,
               ex_mem_rd, mem_wb_rd, ex_mem_regwrite, mem_wb_regwrite,
               branch_taken, ex_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold,
               ex_mem_flush, forward_a, forward_b, stall_cnt, flush_cnt,
               mc_timeout_err
    );
endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// EX-operand forwarding selects for both ALU operands; forced to the
// register file while the pipeline is still being flushed after reset.
module hazard_ctrl_forward_unit
  import hazard_ctrl_pkg::*;
(
    input  logic       enable,
    input  logic [4:0] id_ex_rs1,
    input  logic [4:0] id_ex_rs2,
    input  logic [4:0] ex_mem_rd,
    input  logic [4:0] mem_wb_rd,
    input  logic       ex_mem_regwrite,
    input  logic       mem_wb_regwrite,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (enable) begin
            forward_a = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
            forward_b = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset flush, branch flush, load-use stall,
// multicycle-EX freeze with timeout, forwarding selects and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 4,
    parameter int MC_TIMEOUT        = 64,
    parameter int CNT_W             = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus,
    output state_t       state_dbg
);
    localparam int INIT_W = $clog2(INIT_FLUSH_CYCLES + 1);
    localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);

    state_t             state;
    logic [INIT_W-1:0]  init_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic               mc_timeout_err;

    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_flush;

    assign load_use = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_ex_rd == bus.if_id_rs1)) ||
                       (bus.id_uses_rs2 && (bus.id_ex_rd == bus.if_id_rs2)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (bus.ex_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_hold   = 1'b1;
                    ex_mem_flush = 1'b1;
                    stall_inc    = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                // A multicycle op cannot be a branch, so branch_taken is not looked at here.
                if (bus.ex_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_hold   = 1'b1;
                    ex_mem_flush = 1'b1;
                    stall_inc    = 1'b1;
                end
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            wait_cnt       <= '0;
            stall_cnt      <= '0;
            flush_cnt      <= '0;
            mc_timeout_err <= 1'b0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_W'(INIT_FLUSH_CYCLES - 1)) state <= ST_RUN;
                    else init_cnt <= init_cnt + INIT_W'(1);
                end
                ST_RUN: begin
                    if (!bus.branch_taken && bus.ex_busy) begin
                        state    <= ST_MC_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MC_WAIT: begin
                    if (!bus.ex_busy) state <= ST_RUN;
                    else if (wait_cnt == WAIT_W'(MC_TIMEOUT - 1)) mc_timeout_err <= 1'b1;
                    else wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    hazard_ctrl_forward_unit u_fwd (
        .enable          (state != ST_INIT),
        .id_ex_rs1       (bus.id_ex_rs1),
        .id_ex_rs2       (bus.id_ex_rs2),
        .ex_mem_rd       (bus.ex_mem_rd),
        .mem_wb_rd       (bus.mem_wb_rd),
        .ex_mem_regwrite (bus.ex_mem_regwrite),
        .mem_wb_regwrite (bus.mem_wb_regwrite),
        .forward_a       (bus.forward_a),
        .forward_b       (bus.forward_b)
    );

    assign bus.pc_write       = pc_write;
    assign bus.if_id_write    = if_id_write;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.id_ex_hold     = id_ex_hold;
    assign bus.ex_mem_flush   = ex_mem_flush;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.flush_cnt      = flush_cnt;
    assign bus.mc_timeout_err = mc_timeout_err;
    assign state_dbg          = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset/INIT flush, load-use, branch priority,
// multicycle freeze and timeout, forwarding selects, reset out of MC_WAIT.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     tests;
  int     fails;
  int     exp_stall;
  int     exp_flush;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(
    .INIT_FLUSH_CYCLES (4),
    .MC_TIMEOUT        (64),
    .CNT_W             (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.if_id_rs1 = 5'd0;  bus.if_id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.id_ex_rd = 5'd0;   bus.id_ex_rs1 = 5'd0;  bus.id_ex_rs2 = 5'd0;
    bus.id_ex_memread = 1'b0;
    bus.ex_mem_rd = 5'd0;  bus.mem_wb_rd = 5'd0;
    bus.ex_mem_regwrite = 1'b0; bus.mem_wb_regwrite = 1'b0;
    bus.branch_taken = 1'b0; bus.ex_busy = 1'b0;
  endtask

  // advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_freeze(input string tag);
    chk({tag, "_pc_write"}, 32'(bus.pc_write), 32'd0);
    chk({tag, "_if_id_write"}, 32'(bus.if_id_write), 32'd0);
    chk({tag, "_id_ex_hold"}, 32'(bus.id_ex_hold), 32'd1);
    chk({tag, "_ex_mem_flush"}, 32'(bus.ex_mem_flush), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; exp_stall = 0; exp_flush = 0;
    rst_n = 1'b0;
    clear_inputs();

    // reset asserted
    step(); step();
    chk("rst_state", 32'(state_dbg), 32'(ST_INIT));
    chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
    chk("rst_if_id_flush", 32'(bus.if_id_flush), 32'd1);
    chk("rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    chk("rst_ex_mem_flush", 32'(bus.ex_mem_flush), 32'd1);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_err", 32'(bus.mc_timeout_err), 32'd0);

    // release; inputs must be ignored throughout INIT
    rst_n = 1'b1;
    bus.branch_taken = 1'b1; bus.ex_busy = 1'b1;
    bus.ex_mem_regwrite = 1'b1; bus.ex_mem_rd = 5'd7; bus.id_ex_rs1 = 5'd7;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("init%0d_id_ex_flush", k), 32'(bus.id_ex_flush), 32'd1);
      chk($sformatf("init%0d_if_id_flush", k), 32'(bus.if_id_flush), 32'd1);
      chk($sformatf("init%0d_pc_write", k), 32'(bus.pc_write), 32'd0);
      chk($sformatf("init%0d_fwd_a", k), 32'(bus.forward_a), 32'(FWD_RF));
      step();
    end
    chk("init_done_state", 32'(state_dbg), 32'(ST_RUN));
    chk("init_flush_cnt", bus.flush_cnt, 32'd0);
    chk("init_stall_cnt", bus.stall_cnt, 32'd0);
    clear_inputs();
    #1;
    chk("run_pc_write", 32'(bus.pc_write), 32'd1);
    chk("run_if_id_write", 32'(bus.if_id_write), 32'd1);
    chk("run_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);

    // load-use on rs2
    bus.id_ex_memread = 1'b1; bus.id_ex_rd = 5'd5;
    bus.if_id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    #1;
    chk("lu_pc_write", 32'(bus.pc_write), 32'd0);
    chk("lu_if_id_write", 32'(bus.if_id_write), 32'd0);
    chk("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    chk("lu_if_id_flush", 32'(bus.if_id_flush), 32'd0);
    step(); exp_stall++;
    chk("lu_stall_cnt", bus.stall_cnt, 32'(exp_stall));
    bus.id_ex_memread = 1'b0;
    #1;
    chk("lu_after_pc_write", 32'(bus.pc_write), 32'd1);
    chk("lu_after_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);
    // match on an unused source is not a hazard
    bus.id_ex_memread = 1'b1; bus.id_uses_rs2 = 1'b0;
    #1;
    chk("lu_unused_pc_write", 32'(bus.pc_write), 32'd1);
    // load to x0 is not a hazard
    bus.id_ex_rd = 5'd0; bus.if_id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
    #1;
    chk("lu_x0_pc_write", 32'(bus.pc_write), 32'd1);
    step();
    chk("lu_neg_stall_cnt", bus.stall_cnt, 32'(exp_stall));
    clear_inputs();

    // branch beats a concurrent load-use
    bus.id_ex_memread = 1'b1; bus.id_ex_rd = 5'd5;
    bus.if_id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1; bus.branch_taken = 1'b1;
    #1;
    chk("br_if_id_flush", 32'(bus.if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    chk("br_pc_write", 32'(bus.pc_write), 32'd1);
    step(); exp_flush++;
    chk("br_flush_cnt", bus.flush_cnt, 32'(exp_flush));
    chk("br_stall_cnt", bus.stall_cnt, 32'(exp_stall));
    clear_inputs();

    // branch beats ex_busy: no freeze, no MC_WAIT
    bus.branch_taken = 1'b1; bus.ex_busy = 1'b1;
    #1;
    chk("brbusy_hold", 32'(bus.id_ex_hold), 32'd0);
    step(); exp_flush++;
    chk("brbusy_state", 32'(state_dbg), 32'(ST_RUN));
    chk("brbusy_flush_cnt", bus.flush_cnt, 32'(exp_flush));
    clear_inputs();

    // ex_busy for 3 cycles; branch_taken in MC_WAIT is ignored
    bus.ex_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.branch_taken = (i == 2);
      #1;
      chk_freeze($sformatf("mc%0d", i));
      chk($sformatf("mc%0d_if_id_flush", i), 32'(bus.if_id_flush), 32'd0);
      step(); exp_stall++;
      chk($sformatf("mc%0d_state", i), 32'(state_dbg), 32'(ST_MC_WAIT));
    end
    clear_inputs();
    #1;
    chk("mc_end_pc_write", 32'(bus.pc_write), 32'd1);
    chk("mc_end_hold", 32'(bus.id_ex_hold), 32'd0);
    step();
    chk("mc_end_state", 32'(state_dbg), 32'(ST_RUN));
    chk("mc_stall_cnt", bus.stall_cnt, 32'(exp_stall));
    chk("mc_flush_cnt", bus.flush_cnt, 32'(exp_flush));
    chk("mc_err", 32'(bus.mc_timeout_err), 32'd0);

    // ex_busy for 70 cycles trips the timeout
    bus.ex_busy = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step(); exp_stall++;
    end
    chk("to_err", 32'(bus.mc_timeout_err), 32'd1);
    chk("to_state", 32'(state_dbg), 32'(ST_MC_WAIT));
    bus.ex_busy = 1'b0;
    step(); step();
    chk("to_err_sticky", 32'(bus.mc_timeout_err), 32'd1);
    chk("to_state_run", 32'(state_dbg), 32'(ST_RUN));
    chk("to_stall_cnt", bus.stall_cnt, 32'(exp_stall));

    // forwarding
    bus.ex_mem_rd = 5'd7; bus.mem_wb_rd = 5'd7; bus.id_ex_rs1 = 5'd7;
    bus.ex_mem_regwrite = 1'b1; bus.mem_wb_regwrite = 1'b1;
    #1;
    chk("fwd_a_double", 32'(bus.forward_a), 32'(2'b10));
    bus.ex_mem_rd = 5'd0;
    #1;
    chk("fwd_a_wb", 32'(bus.forward_a), 32'(2'b01));
    bus.mem_wb_regwrite = 1'b0;
    #1;
    chk("fwd_a_nowe", 32'(bus.forward_a), 32'(2'b00));
    bus.mem_wb_rd = 5'd0; bus.mem_wb_regwrite = 1'b1; bus.id_ex_rs2 = 5'd0;
    #1;
    chk("fwd_b_x0", 32'(bus.forward_b), 32'(2'b00));
    bus.ex_mem_rd = 5'd3; bus.id_ex_rs2 = 5'd3;
    #1;
    chk("fwd_b_mem", 32'(bus.forward_b), 32'(2'b10));
    chk("fwd_a_none", 32'(bus.forward_a), 32'(2'b00));

    // reset pulse while in MC_WAIT
    bus.ex_busy = 1'b1;
    step();
    chk("prerst_state", 32'(state_dbg), 32'(ST_MC_WAIT));
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state_dbg), 32'(ST_INIT));
    chk("midrst_pc_write", 32'(bus.pc_write), 32'd0);
    chk("midrst_if_id_flush", 32'(bus.if_id_flush), 32'd1);
    chk("midrst_hold", 32'(bus.id_ex_hold), 32'd0);
    chk("midrst_fwd_b", 32'(bus.forward_b), 32'(2'b00));
    chk("midrst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("midrst_flush_cnt", bus.flush_cnt, 32'd0);
    chk("midrst_err", 32'(bus.mc_timeout_err), 32'd0);
    step();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
